// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational 4-bit ALU between two requesters,
// with registered issue/capture and a valid/ready response. Optional: ALU_SHARE_MUL_EN.
module alu_share_arbiter #(
    parameter bit RR_INIT   = 1'b0,
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_a,
    input  logic [3:0]  req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_a,
    input  logic [3:0]  req1_b,
    input  logic [4:0]  req1_op,
    output logic [12:0] alu_in,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [3:0]  resp_result,
    output logic        resp_carry,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
`ifdef ALU_SHARE_MUL_EN
        S_MUL_INIT,
        S_MUL_ISSUE,
        S_MUL_CAPTURE,
        S_MUL_SKIP,
        S_MUL_DONE,
`endif
        S_RESP
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        cur_id;
    logic        grant_id;
    logic        accept;
    logic [12:0] grant_word;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end
        accept     = (state == S_IDLE) && (req0_valid || req1_valid);
        grant_word = grant_id ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

`ifdef ALU_SHARE_MUL_EN
    localparam logic [4:0] OP_ADD = 5'b10000;
    localparam logic [4:0] OP_MUL = 5'b11111;

    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [3:0] acc;
    logic [3:0] acc_cur;
    logic [1:0] mul_i;
    logic [1:0] mul_j;
    logic [7:0] mul_shift;
    logic       ovf;
    logic       ovf_cur;
    logic       mul_last;

    // acc_cur/ovf_cur fold in the ALU output on the capture cycle so the next
    // step can be launched on the same edge that captures the previous one.
    always_comb begin
        mul_j     = (state == S_MUL_INIT) ? 2'd0 : mul_i + 2'd1;
        mul_last  = (state != S_MUL_INIT) && (mul_i == 2'd3);
        mul_shift = {4'b0000, mul_a} << mul_j;
        acc_cur   = (state == S_MUL_CAPTURE) ? alu_result : acc;
        ovf_cur   = ovf | ((state == S_MUL_CAPTURE) && alu_carry);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            alu_in      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_carry  <= 1'b0;
            busy        <= 1'b0;
            last_grant  <= RR_INIT;
            cur_id      <= 1'b0;
`ifdef ALU_SHARE_MUL_EN
            mul_a       <= '0;
            mul_b       <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
            mul_i       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_in     <= grant_word;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b1;
`ifdef ALU_SHARE_MUL_EN
                        if (grant_word[4:0] == OP_MUL) begin
                            mul_a <= grant_word[12:9];
                            mul_b <= grant_word[8:5];
                            acc   <= '0;
                            ovf   <= 1'b0;
                            mul_i <= '0;
                            state <= S_MUL_INIT;
                        end else begin
                            state <= S_ISSUE;
                        end
`else
                        state <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    resp_result <= alu_result;
                    resp_carry  <= alu_carry;
                    resp_id     <= cur_id;
                    resp_valid  <= 1'b1;
                    if (IDLE_ZERO) begin
                        alu_in <= '0;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
`ifdef ALU_SHARE_MUL_EN
                S_MUL_INIT, S_MUL_SKIP, S_MUL_CAPTURE: begin
                    acc <= acc_cur;
                    if (mul_last) begin
                        ovf   <= ovf_cur;
                        state <= S_MUL_DONE;
                    end else if (mul_b[mul_j]) begin
                        // Bits of a pushed past bit 3 by the shift are lost product weight.
                        alu_in <= {acc_cur, mul_shift[3:0], OP_ADD};
                        ovf    <= ovf_cur | (|mul_shift[7:4]);
                        mul_i  <= mul_j;
                        state  <= S_MUL_ISSUE;
                    end else begin
                        ovf   <= ovf_cur;
                        mul_i <= mul_j;
                        state <= S_MUL_SKIP;
                    end
                end
                S_MUL_ISSUE: state <= S_MUL_CAPTURE;
                S_MUL_DONE: begin
                    resp_result <= acc;
                    resp_carry  <= ovf;
                    resp_id     <= cur_id;
                    resp_valid  <= 1'b1;
                    if (IDLE_ZERO) begin
                        alu_in <= '0;
                    end
                    state <= S_RESP;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
